// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-port arbiter for a registered-read data memory; define DMEM_ARB_RR_EN for round robin
module data_memory_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [31:0]       p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_err_o,
  output logic              p0_rvalid_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_err_o,
  output logic              p1_rvalid_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2;
  logic [1:0] state;
  logic win, we, rej, acc, pick;
  logic [31:0] addr;
  logic [DATA_W-1:0] wdata;
`ifdef DMEM_ARB_RR_EN
  logic last;
  // on contention serve the port that was not granted last time
  always_comb pick = (p0_req_i & p1_req_i) ? ~last : ~p0_req_i;
  always_ff @(posedge clk_i)
    if (rst_i) last <= 1'b1;
    else if (state == ISSUE) last <= win;
`else
  always_comb pick = ~p0_req_i;
`endif
  always_comb begin
    rej = |addr[1:0] | |addr[31:ADDR_W];
    acc = (state == ISSUE) & ~rej;
  end
  assign p0_gnt_o    = (state == ISSUE) & ~win;
  assign p1_gnt_o    = (state == ISSUE) & win;
  assign p0_err_o    = p0_gnt_o & rej;
  assign p1_err_o    = p1_gnt_o & rej;
  assign mem_read_o  = acc & ~we;
  assign mem_write_o = acc & we;
  assign mem_addr_o  = acc ? addr : 32'd0;
  assign mem_data_o  = acc ? wdata : '0;
  assign busy_o      = state != IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      win         <= 1'b0;
      we          <= 1'b0;
      addr        <= 32'd0;
      wdata       <= '0;
      p0_rdata_o  <= '0;
      p1_rdata_o  <= '0;
      p0_rvalid_o <= 1'b0;
      p1_rvalid_o <= 1'b0;
    end else begin
      p0_rvalid_o <= 1'b0;
      p1_rvalid_o <= 1'b0;
      case (state)
        IDLE: if (p0_req_i | p1_req_i) begin
          win   <= pick;
          we    <= pick ? p1_we_i : p0_we_i;
          addr  <= pick ? p1_addr_i : p0_addr_i;
          wdata <= pick ? p1_wdata_i : p0_wdata_i;
          state <= ISSUE;
        end
        ISSUE: state <= (rej | we) ? IDLE : CAPTURE;
        CAPTURE: begin
          if (win) begin
            p1_rdata_o  <= mem_data_i;
            p1_rvalid_o <= 1'b1;
          end else begin
            p0_rdata_o  <= mem_data_i;
            p0_rvalid_o <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: randomized and directed checks against a word-array reference model
module tb_data_memory_arbiter;
  logic clk = 0, rst = 0;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic p0_gnt, p0_err, p0_rv, p1_gnt, p1_err, p1_rv, mem_read, mem_write, busy;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_data, mem_q;
  logic [31:0] mem [8];
  logic [31:0] ref_mem [8];
  logic [31:0] exp_rdata [2];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_gnt_o(p0_gnt), .p0_err_o(p0_err), .p0_rvalid_o(p0_rv), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_gnt_o(p1_gnt), .p1_err_o(p1_err), .p1_rvalid_o(p1_rv), .p1_rdata_o(p1_rdata),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_data_i(mem_q), .busy_o(busy)
  );

  // external single-port memory with registered read
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[4:2]] <= mem_data;
    if (mem_read) mem_q <= mem[mem_addr[4:2]];
  end

  task automatic predict(input int port, input logic w, input logic [31:0] a, d, output logic [109:0] e);
    logic rej, acc;
    logic [31:0] rd;
    rej = (a[1:0] != 0) || (a[31:5] != 0);
    acc = !rej;
    if (acc && w) ref_mem[a[4:2]] = d;
    if (acc && !w) exp_rdata[port] = ref_mem[a[4:2]];
    rd = exp_rdata[port];
    e = {port == 0, port == 1, rej && port == 0, rej && port == 1, acc && !w, acc && w,
         acc ? a : 32'd0, acc ? d : 32'd0, 6'd0, acc && !w && port == 0, acc && !w && port == 1, rd};
  endtask

  task automatic run_op(input int port, input logic w, input logic [31:0] a, d, output logic [109:0] o);
    logic [69:0] iss;
    logic [5:0] s2;
    logic [1:0] rv3;
    logic [31:0] rd;
    if (port == 0) begin p0_req = 1; p0_we = w; p0_addr = a; p0_wdata = d; end
    else begin p1_req = 1; p1_we = w; p1_addr = a; p1_wdata = d; end
    @(posedge clk); #1;
    iss = {p0_gnt, p1_gnt, p0_err, p1_err, mem_read, mem_write, mem_addr, mem_data};
    p0_req = 0; p1_req = 0;
    @(posedge clk); #1;
    s2 = {p0_rv, p1_rv, mem_read, mem_write, p0_gnt, p1_gnt};
    rv3 = 2'b00;
    if (!w) begin @(posedge clk); #1; rv3 = {p0_rv, p1_rv}; end
    rd = port ? p1_rdata : p0_rdata;
    o = {iss, s2, rv3, rd};
  endtask

  task automatic test_reset();
    logic [233:0] z;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    z = {p0_gnt, p1_gnt, p0_err, p1_err, p0_rv, p1_rv, mem_read, mem_write, busy, mem_addr, mem_data, p0_rdata, p1_rdata};
    checks++;
    if (z !== 0) begin errors++; $display("FAIL reset_outputs: got %h want 0", z); end
    rst = 0;
    @(posedge clk); #1;
    checks++;
    if ({busy, p0_gnt, p1_gnt} !== 3'b000) begin errors++; $display("FAIL reset_idle: got %b want 000", {busy, p0_gnt, p1_gnt}); end
  endtask

  task automatic test_write_read();
    logic [109:0] e, o;
    predict(0, 1, 32'd8, 32'hDEADBEEF, e); run_op(0, 1, 32'd8, 32'hDEADBEEF, o);
    checks++;
    if (o !== e) begin errors++; $display("FAIL write_read wr: got %h want %h", o, e); end
    predict(0, 0, 32'd8, 32'd0, e); run_op(0, 0, 32'd8, 32'd0, o);
    checks++;
    if (o !== e) begin errors++; $display("FAIL write_read rd: got %h want %h", o, e); end
  endtask

  task automatic test_reject();
    logic [109:0] e, o;
    logic [31:0] addrs [3] = '{32'd8, 32'd6, 32'd32};
    for (int i = 0; i < 3; i++) begin
      predict(1, 0, addrs[i], 32'd0, e); run_op(1, 0, addrs[i], 32'd0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL reject addr=%0d: got %h want %h", addrs[i], o, e); end
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] g [3];
    logic [1:0] want [3];
`ifdef DMEM_ARB_RR_EN
    want = '{2'b10, 2'b01, 2'b10};
`else
    want = '{2'b10, 2'b10, 2'b10};
`endif
    p0_req = 1; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 1; p1_we = 0; p1_addr = 4; p1_wdata = 0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c % 3 == 1) g[c / 3] = {p0_gnt, p1_gnt};
    end
    p0_req = 0; p1_req = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_rdata[0] = ref_mem[0];
`ifdef DMEM_ARB_RR_EN
    exp_rdata[1] = ref_mem[1];
`endif
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (g[i] !== want[i]) begin errors++; $display("FAIL arbitration grant%0d: got %b want %b", i, g[i], want[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [109:0] e, o;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = (i < 4) ? $urandom : 32'd0;
      predict(0, i < 4, 32'(4 * (i % 4)), d, e); run_op(0, i < 4, 32'(4 * (i % 4)), d, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back op%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_capture_reset();
    logic [109:0] e, o;
    logic [233:0] z;
    p0_req = 1; p0_we = 0; p0_addr = 8;
    @(posedge clk); #1;
    p0_req = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    z = {p0_gnt, p1_gnt, p0_err, p1_err, p0_rv, p1_rv, mem_read, mem_write, busy, mem_addr, mem_data, p0_rdata, p1_rdata};
    checks++;
    if (z !== 0) begin errors++; $display("FAIL capture_reset outputs: got %h want 0", z); end
    exp_rdata[0] = 0; exp_rdata[1] = 0;
    predict(0, 0, 32'd8, 32'd0, e); run_op(0, 0, 32'd8, 32'd0, o);
    checks++;
    if (o !== e) begin errors++; $display("FAIL capture_reset read: got %h want %h", o, e); end
  endtask

  task automatic test_rvalid_overlap();
    logic [31:0] d;
    d = $urandom;
    p1_req = 1; p1_we = 0; p1_addr = 12;
    @(posedge clk); #1;
    p1_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({p1_rv, p1_rdata} !== {1'b1, ref_mem[3]}) begin errors++; $display("FAIL overlap p1 read: got %b/%h want 1/%h", p1_rv, p1_rdata, ref_mem[3]); end
    exp_rdata[1] = ref_mem[3];
    p0_req = 1; p0_we = 1; p0_addr = 16; p0_wdata = d;
    @(posedge clk); #1;
    p0_req = 0;
    checks++;
    if ({p0_gnt, mem_write, mem_addr, mem_data} !== {2'b11, 32'd16, d}) begin
      errors++; $display("FAIL overlap p0 write: got %b%b/%h/%h want 11/10/%h", p0_gnt, mem_write, mem_addr, mem_data, d);
    end
    ref_mem[4] = d;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [109:0] e, o;
    logic [31:0] a, d;
    int port, k;
    logic w;
    for (int i = 0; i < 40; i++) begin
      port = $urandom_range(1);
      w = 1'($urandom_range(1));
      k = $urandom_range(9);
      a = (k < 8) ? 32'(4 * k) : (k == 8) ? 32'(4 * $urandom_range(7) + $urandom_range(1, 3)) : 32'($urandom_range(32, 4096));
      d = w ? $urandom : 32'd0;
      predict(port, w, a, d, e); run_op(port, w, a, d, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL random op%0d p%0d we=%b a=%h: got %h want %h", i, port, w, a, o, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    exp_rdata[0] = 0; exp_rdata[1] = 0;
    test_reset();
    test_write_read();
    test_reject();
    test_arbitration();
    test_back_to_back();
    test_capture_reset();
    test_rvalid_overlap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
